// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with runtime almost-full/empty levels,
// standard or first-word-fall-through read, flush and sticky error flags.
module sync_fifo_prog #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16384,
  parameter int FWFT  = 0,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             RE,
  input  logic [CNT_W-1:0] AF_THRESH,
  input  logic [CNT_W-1:0] AE_THRESH,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [CNT_W-1:0] WRCNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int PTR_W = CNT_W - 1;
  localparam bit FW = (FWFT != 0);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_stg;
  logic [WIDTH-1:0] r_ram_q;
  logic [WIDTH-1:0] r_q;
  logic             r_s1_v;
  logic             r_dvld;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_unf;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_out_ld;
  logic             w_ram_rd;
  logic             w_q_ld;

  // FWFT: empty means nothing presented; standard: nothing stored
  assign w_empty  = FW ? !r_dvld : r_empty;
  assign w_wr     = WE && !r_full;
  assign w_rd     = RE && !w_empty;
  // words already pulled out of RAM into the prefetch stages
  assign w_stg    = CNT_W'(r_s1_v) + CNT_W'(r_dvld);
  assign w_out_ld = r_s1_v && (!r_dvld || w_rd);
  assign w_q_ld   = FW ? w_out_ld : r_s1_v;

  // RAM read issue: prefetch refill in FWFT, accepted read otherwise
  always_comb begin
    w_ram_rd = 1'b0;
    if (FW) begin
      w_ram_rd = (r_cnt > w_stg) && (!r_s1_v || w_out_ld);
    end else begin
      w_ram_rd = w_rd;
    end
  end

  // next occupancy from accepted write/read pair
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr, w_rd})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // storage array with registered read port
  always_ff @(posedge CLK) begin
    if (w_wr && RESET_N && !CLR) begin
      r_mem[r_wptr] <= DATA;
    end
    if (w_ram_rd) begin
      r_ram_q <= r_mem[r_rptr];
    end
  end

  // pointers, occupancy, status flags and read pipeline valids
  always_ff @(posedge CLK) begin
    if (!RESET_N || CLR) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_s1_v   <= 1'b0;
      r_dvld   <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_ram_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == DEPTH_C);
      r_empty  <= (w_cnt_nxt == '0);
      r_afull  <= (w_cnt_nxt >= AF_THRESH);
      r_aempty <= (w_cnt_nxt <= AE_THRESH);
      if (WE && r_full) begin
        r_ovf <= 1'b1;
      end
      if (RE && w_empty) begin
        r_unf <= 1'b1;
      end
      if (FW) begin
        if (w_ram_rd) begin
          r_s1_v <= 1'b1;
        end else if (w_out_ld) begin
          r_s1_v <= 1'b0;
        end
        if (w_out_ld) begin
          r_dvld <= 1'b1;
        end else if (w_rd) begin
          r_dvld <= 1'b0;
        end
      end else begin
        r_s1_v <= w_ram_rd;
        r_dvld <= r_s1_v;
      end
    end
  end

  // output data register: cleared by reset, held through a flush
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_q <= '0;
    end else if (!CLR && w_q_ld) begin
      r_q <= r_ram_q;
    end
  end

  assign Q         = r_q;
  assign DVLD      = r_dvld;
  assign FULL      = r_full;
  assign EMPTY     = w_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign WRCNT     = r_cnt;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;

endmodule
